// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU port (P0)
// and a DMA/debug port (P1), with a bounded P1 burst lock and registered read return.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int BURST_MAX       = 4
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       p0_req,
  input  logic                       p0_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] p0_addr,
  input  logic [63:0]                p0_wdata,
  output logic                       p0_gnt,
  output logic                       p0_rvalid,
  output logic [63:0]                p0_rdata,
  input  logic                       p1_req,
  input  logic                       p1_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] p1_addr,
  input  logic [63:0]                p1_wdata,
  input  logic                       p1_lock,
  output logic                       p1_gnt,
  output logic                       p1_rvalid,
  output logic [63:0]                p1_rdata,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]                mem_din,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [63:0]                mem_dout
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

  // rr_ptr: 0 means P0 wins the next contended cycle, 1 means P1 does.
  logic          rr_ptr_q, rr_ptr_d;
  logic          p1_last_q, p1_last_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          p0_rvalid_q, p0_rvalid_d;
  logic          p1_rvalid_q, p1_rvalid_d;
  logic [63:0]   p0_rdata_q, p0_rdata_d;
  logic [63:0]   p1_rdata_q, p1_rdata_d;

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (reset_b) begin
      if (p0_req && p1_req) begin
        if (p1_last_q && p1_lock && (burst_cnt_q < BURST_LIM)) begin
          p1_gnt = 1'b1;
        end else if (rr_ptr_q) begin
          p1_gnt = 1'b1;
        end else begin
          p0_gnt = 1'b1;
        end
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (p0_gnt) begin
      mem_addr  = p0_addr;
      mem_din   = p0_wdata;
      mem_write = p0_we;
      mem_read  = ~p0_we;
    end else if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_din   = p1_wdata;
      mem_write = p1_we;
      mem_read  = ~p1_we;
    end
  end

  // The burst counter only advances while P1 holds the memory against a waiting P0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (p0_gnt) begin
      rr_ptr_d = 1'b1;
    end else if (p1_gnt) begin
      rr_ptr_d = 1'b0;
    end
    p1_last_d   = p1_gnt;
    burst_cnt_d = '0;
    if (p1_gnt && p1_lock && p0_req) begin
      burst_cnt_d = (burst_cnt_q == BURST_LIM) ? burst_cnt_q : burst_cnt_q + CW'(1);
    end
    p0_rvalid_d = p0_gnt & ~p0_we;
    p1_rvalid_d = p1_gnt & ~p1_we;
    p0_rdata_d  = p0_rvalid_d ? mem_dout : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_dout : p1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rr_ptr_q    <= 1'b0;
      p1_last_q   <= 1'b0;
      burst_cnt_q <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      p1_last_q   <= p1_last_d;
      burst_cnt_q <= burst_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int BURST_MAX = 4;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [63:0]   p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [63:0]   p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_din, mem_dout;
  logic          mem_read, mem_write;

  int checks = 0;
  int errors = 0;

  logic [63:0] dmem    [1024];
  logic [63:0] ref_mem [1024];

  dmem_arbiter #(.DMEM_ADDR_WIDTH(AW), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset_b(reset_b),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port memory stub: combinational read, write committed at the clock edge.
  assign mem_dout = dmem[mem_addr];
  always @(posedge clk) if (mem_write) dmem[mem_addr] <= mem_din;

  function automatic logic [63:0] init_val(input int i);
    return {32'hDEAD0000 + 32'(i), 32'h0BEE0000 ^ 32'(i * 7)};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i]    = init_val(i);
      ref_mem[i] = init_val(i);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [63:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [63:0] d1,
                       input logic lk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    p1_lock = lk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who should win from the arbitration rules, and what each port's
  // registered read return should look like, tracked against a shadow memory.
  bit          m_valid = 0;
  int          m_pref = 0;
  bit          m_last1 = 0;
  int          m_streak = 0;
  logic        m_rv [2];
  logic [63:0] m_rd [2];

  always begin
    int win;
    logic s_rst, s_r0, s_w0, s_r1, s_w1, s_lk;
    logic [AW-1:0] s_a0, s_a1, wa;
    logic [63:0] s_d0, s_d1, wd;
    logic ww;
    @(negedge clk);
    s_rst = reset_b;
    s_r0 = p0_req; s_w0 = p0_we; s_a0 = p0_addr; s_d0 = p0_wdata;
    s_r1 = p1_req; s_w1 = p1_we; s_a1 = p1_addr; s_d1 = p1_wdata;
    s_lk = p1_lock;
    win = -1;
    if (s_rst) begin
      if (s_r0 && s_r1) win = (m_last1 && s_lk && m_streak < BURST_MAX) ? 1 : m_pref;
      else if (s_r0) win = 0;
      else if (s_r1) win = 1;
    end
    ww = (win == 0) ? s_w0 : s_w1;
    wa = (win == 0) ? s_a0 : s_a1;
    wd = (win == 0) ? s_d0 : s_d1;
    if (m_valid) begin
      check("m_p0_gnt", p0_gnt, (win == 0));
      check("m_p1_gnt", p1_gnt, (win == 1));
      check("m_gnt_excl", p0_gnt & p1_gnt, 0);
      check("m_mem_read", mem_read, (win >= 0) && !ww);
      check("m_mem_write", mem_write, (win >= 0) && ww);
      if (s_rst) begin
        check("m_mem_addr", mem_addr, (win >= 0) ? wa : '0);
        check("m_mem_din", mem_din, (win >= 0) ? wd : '0);
      end
      check("m_p0_rvalid", p0_rvalid, m_rv[0]);
      check("m_p1_rvalid", p1_rvalid, m_rv[1]);
      check("m_p0_rdata", p0_rdata, m_rd[0]);
      check("m_p1_rdata", p1_rdata, m_rd[1]);
    end
    @(posedge clk);
    if (!s_rst) begin
      m_valid = 1; m_pref = 0; m_last1 = 0; m_streak = 0;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    end else if (m_valid) begin
      m_rv[0] = 0; m_rv[1] = 0;
      if (win >= 0) begin
        if (ww) ref_mem[wa] = wd;
        else begin
          m_rv[win] = 1;
          m_rd[win] = ref_mem[wa];
        end
        m_pref = 1 - win;
      end
      if (win == 1 && s_lk && s_r0) m_streak = (m_streak < BURST_MAX) ? m_streak + 1 : BURST_MAX;
      else m_streak = 0;
      m_last1 = (win == 1);
    end
  end

  initial begin
    logic [3:0] seq3;
    logic [5:0] seq4;
    reset_b = 1'b0;
    drive(1, 0, 10'h001, 64'h0, 1, 0, 10'h002, 64'h0, 0);
    step();

    // Reset with both ports requesting
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_p0_gnt", p0_gnt, 0);
      check("rst_p1_gnt", p1_gnt, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset_b = 1'b1;
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    step();

    // P0 write then read back
    drive(1, 1, 10'h010, 64'h1122334455667788, 0, 0, 0, 0, 0);
    #1;
    check("wr_p0_gnt", p0_gnt, 1);
    check("wr_mem_write", mem_write, 1);
    check("wr_mem_addr", mem_addr, 10'h010);
    step();
    drive(1, 0, 10'h010, 64'h0, 0, 0, 0, 0, 0);
    #1;
    check("rd_p0_gnt", p0_gnt, 1);
    check("rd_mem_read", mem_read, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_p0_rvalid", p0_rvalid, 1);
    check("rd_p0_rdata", p0_rdata, 64'h1122334455667788);
    step();
    check("rd_p0_rvalid_drop", p0_rvalid, 0);

    // Contended round robin without lock
    drive(0, 0, 0, 0, 1, 0, 10'h005, 0, 0);
    step();
    seq3 = 4'b1010;
    drive(1, 0, 10'h001, 0, 1, 0, 10'h002, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_p0_gnt", p0_gnt, !seq3[i]);
      check("rr_p1_gnt", p1_gnt, seq3[i]);
      step();
    end

    // Burst lock: four P1 grants, one P0, then P1 again
    drive(0, 0, 0, 0, 1, 0, 10'h006, 0, 1);
    step();
    seq4 = 6'b101111;
    drive(1, 0, 10'h003, 0, 1, 0, 10'h007, 0, 1);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("burst_p0_gnt", p0_gnt, !seq4[i]);
      check("burst_p1_gnt", p1_gnt, seq4[i]);
      step();
    end

    // P1 alone, back-to-back reads of preloaded contents
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, 0, AW'(i), 0, 1);
      #1;
      check("seq_p1_gnt", p1_gnt, 1);
      step();
      check("seq_p1_rvalid", p1_rvalid, 1);
      check("seq_p1_rdata", p1_rdata, init_val(i));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("seq_p1_rvalid_drop", p1_rvalid, 0);

    // Reset in the middle of a P1 burst
    drive(0, 0, 0, 0, 1, 0, 10'h003, 0, 1);
    step();
    drive(1, 0, 10'h008, 0, 1, 0, 10'h004, 0, 1);
    #1;
    check("mid_p1_gnt", p1_gnt, 1);
    step();
    check("mid_p1_rvalid", p1_rvalid, 1);
    reset_b = 1'b0;
    #1;
    check("mid_rst_p1_gnt", p1_gnt, 0);
    check("mid_rst_p0_gnt", p0_gnt, 0);
    step();
    check("mid_rst_p1_rvalid", p1_rvalid, 0);
    reset_b = 1'b1;
    #1;
    check("post_rst_p0_gnt", p0_gnt, 1);
    check("post_rst_p1_gnt", p1_gnt, 0);
    step();

    // Random traffic on a small address window to force read-after-write hits
    for (int i = 0; i < 500; i++) begin
      reset_b = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
            {$urandom, $urandom},
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
            {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      step();
    end
    reset_b = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
